// File: rtl/shared_alu_arbiter.sv
// ----------------------------------------------------------------------------
// shared_alu_arbiter
//
// Purpose:
//   Shares one combinational ALU between NUM_REQ requesters. A round-robin
//   arbiter accepts at most one operation per cycle. The selected operands and
//   opcode are registered into an issue stage that drives the ALU. The ALU
//   result is registered one cycle later and returned to the originating
//   requester with a one-cycle valid pulse. Grant locking lets a requester
//   issue back-to-back dependent operations without another requester
//   slipping in between.
//
// Handshake:
//   A transfer happens on a rising edge where i_req_valid[i] & o_req_ready[i].
//   o_req_ready is one-hot and never asserted for a non-valid requester.
//   A requester keeps valid, operands and op stable until its transfer.
//   Responses have no backpressure. The requester must take o_rsp_result in
//   the cycle its o_rsp_valid bit is high.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   i_hold          blocks new grants (in-flight op still completes)
//   i_req_valid     per-requester request
//   i_req_lock      per-requester request to keep the grant next cycle
//   i_req_a/_b      packed operands, requester i at [i*XLEN +: XLEN]
//   i_req_op        packed opcodes, requester i at [i*ALU_OP_WIDTH +: ALU_OP_WIDTH]
//   o_req_ready     one-hot combinational grant
//   o_alu_a/_b/_op  registered ALU inputs (0/0/OP_ADD when idle)
//   i_alu_result    combinational ALU result
//   o_rsp_valid     one-hot one-cycle response pulse
//   o_rsp_result    registered result
//   o_busy          issue or response stage holds a valid op
//
// Opcode encoding follows types.vh; only OP_ADD (0) is used here, as the
// idle value of o_alu_op.
// ----------------------------------------------------------------------------
module shared_alu_arbiter #(
    parameter int XLEN    = 32,
    parameter int NUM_REQ = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_hold,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    input  logic [NUM_REQ-1:0]          i_req_lock,
    input  logic [NUM_REQ*XLEN-1:0]     i_req_a,
    input  logic [NUM_REQ*XLEN-1:0]     i_req_b,
    input  logic [NUM_REQ*5-1:0]        i_req_op,
    output logic [NUM_REQ-1:0]          o_req_ready,
    output logic [XLEN-1:0]             o_alu_a,
    output logic [XLEN-1:0]             o_alu_b,
    output logic [4:0]                  o_alu_op,
    input  logic [XLEN-1:0]             i_alu_result,
    output logic [NUM_REQ-1:0]          o_rsp_valid,
    output logic [XLEN-1:0]             o_rsp_result,
    output logic                        o_busy
);

    localparam int          ALU_OP_WIDTH = 5;
    localparam int          IDW          = (NUM_REQ <= 2) ? 1 : 2;
    localparam logic [4:0]  OP_ADD       = 5'd0;
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDW-1:0]          r_rr_ptr;     // last granted index
    logic                    r_lock_q;
    logic [IDW-1:0]          r_lock_id;

    logic                    r_iss_vld;
    logic [IDW-1:0]          r_iss_id;
    logic [XLEN-1:0]         r_iss_a;
    logic [XLEN-1:0]         r_iss_b;
    logic [ALU_OP_WIDTH-1:0] r_iss_op;

    logic                    r_rsp_vld;
    logic [IDW-1:0]          r_rsp_id;
    logic [XLEN-1:0]         r_rsp_result;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                    w_grant_any;
    logic [IDW-1:0]          w_grant_idx;
    logic                    w_lock_hit;

    // The lock only applies while its holder is still requesting; otherwise
    // normal round-robin takes over in the same cycle.
    assign w_lock_hit = r_lock_q && i_req_valid[r_lock_id];

    always_comb begin
        int cand;
        cand        = 0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        if (!rst && !i_hold) begin
            if (w_lock_hit) begin
                w_grant_any = 1'b1;
                w_grant_idx = r_lock_id;
            end else begin
                // Scan rr_ptr+1, rr_ptr+2, ... so the last winner goes last.
                for (int k = 1; k <= NUM_REQ; k++) begin
                    cand = (int'(r_rr_ptr) + k) % NUM_REQ;
                    if (!w_grant_any && i_req_valid[cand]) begin
                        w_grant_any = 1'b1;
                        w_grant_idx = IDW'(cand);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            o_req_ready[i] = w_grant_any && (w_grant_idx == IDW'(i));
        end
    end

    // A grant is only ever given to a valid requester, so any grant transfers.
    logic w_xfer;
    assign w_xfer = w_grant_any;

    // ------------------------------------------------------------------
    // Issue stage, round-robin pointer and lock state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= LAST_ID;
            r_lock_q  <= 1'b0;
            r_lock_id <= '0;
            r_iss_vld <= 1'b0;
            r_iss_id  <= '0;
            r_iss_a   <= '0;
            r_iss_b   <= '0;
            r_iss_op  <= OP_ADD;
        end else if (w_xfer) begin
            r_rr_ptr  <= w_grant_idx;
            r_lock_q  <= i_req_lock[w_grant_idx];
            r_lock_id <= w_grant_idx;
            r_iss_vld <= 1'b1;
            r_iss_id  <= w_grant_idx;
            r_iss_a   <= i_req_a[w_grant_idx*XLEN +: XLEN];
            r_iss_b   <= i_req_b[w_grant_idx*XLEN +: XLEN];
            r_iss_op  <= i_req_op[w_grant_idx*ALU_OP_WIDTH +: ALU_OP_WIDTH];
        end else begin
            // Idle: park the ALU inputs so the datapath does not toggle.
            r_iss_vld <= 1'b0;
            r_iss_a   <= '0;
            r_iss_b   <= '0;
            r_iss_op  <= OP_ADD;
            // A lock whose holder walked away is released.
            if (r_lock_q && !i_req_valid[r_lock_id]) begin
                r_lock_q <= 1'b0;
            end
        end
    end

    assign o_alu_a  = r_iss_a;
    assign o_alu_b  = r_iss_b;
    assign o_alu_op = r_iss_op;

    // ------------------------------------------------------------------
    // Response stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_vld    <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
        end else begin
            r_rsp_vld <= r_iss_vld;
            r_rsp_id  <= r_iss_id;
            if (r_iss_vld) begin
                r_rsp_result <= i_alu_result;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            o_rsp_valid[i] = r_rsp_vld && (r_rsp_id == IDW'(i));
        end
    end

    assign o_rsp_result = r_rsp_result;
    assign o_busy       = r_iss_vld | r_rsp_vld;

endmodule

// File: tb/tb_shared_alu_arbiter.sv
module tb_shared_alu_arbiter;

  localparam int XLEN = 32;
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SLTU = 5'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            hold;
  logic [1:0]      valid;
  logic [1:0]      lock;
  logic [XLEN-1:0] a0, a1, b0, b1;
  logic [4:0]      op0, op1;

  logic [1:0]      req_ready;
  logic [XLEN-1:0] alu_a, alu_b;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] alu_result;
  logic [1:0]      rsp_valid;
  logic [XLEN-1:0] rsp_result;
  logic            busy;

  shared_alu_arbiter #(.XLEN(XLEN), .NUM_REQ(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_hold       (hold),
    .i_req_valid  (valid),
    .i_req_lock   (lock),
    .i_req_a      ({a1, a0}),
    .i_req_b      ({b1, b0}),
    .i_req_op     ({op1, op0}),
    .o_req_ready  (req_ready),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_op     (alu_op),
    .i_alu_result (alu_result),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_result (rsp_result),
    .o_busy       (busy)
  );

  // Small ALU model standing in for the shared ALU instance.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_SLTU: alu_result = {31'b0, (alu_a < alu_b)};
      default: alu_result = '0;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Move to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hold  = 1'b0;
    valid = 2'b00;
    lock  = 2'b00;
  endtask

  // Hand-computed expectations
  logic [1:0]      rr_ready [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
  logic [1:0]      lk_ready [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
  logic [XLEN-1:0] lk_res   [4] = '{32'd11, 32'd12, 32'd13, 32'd100};
  int              wait1;

  initial begin
    idle_inputs();
    a0 = '0; a1 = '0; b0 = '0; b1 = '0; op0 = OP_ADD; op1 = OP_ADD;

    // ---- reset with all requests valid ----
    valid = 2'b11;
    rst   = 1'b1;
    step(); step(); step();
    check("rst_ready",  {30'b0, req_ready}, 32'd0);
    check("rst_alu_a",  alu_a, 32'd0);
    check("rst_alu_b",  alu_b, 32'd0);
    check("rst_alu_op", {27'b0, alu_op}, {27'b0, OP_ADD});
    check("rst_rsp_v",  {30'b0, rsp_valid}, 32'd0);
    check("rst_rsp_r",  rsp_result, 32'd0);
    check("rst_busy",   {31'b0, busy}, 32'd0);
    rst = 1'b0;
    #1;
    check("first_grant", {30'b0, req_ready}, 32'd1);
    valid = 2'b00;
    step(); step();

    // ---- single op from requester 1: 5 + 7 ----
    valid = 2'b10; a1 = 32'd5; b1 = 32'd7; op1 = OP_ADD;
    #1;
    check("single_ready", {30'b0, req_ready}, 32'd2);
    step();                      // transfer edge k
    valid = 2'b00;
    check("single_alu_a",  alu_a, 32'd5);
    check("single_alu_b",  alu_b, 32'd7);
    check("single_busy",   {31'b0, busy}, 32'd1);
    check("single_rsp_v0", {30'b0, rsp_valid}, 32'd0);
    step();                      // edge k+1
    check("single_rsp_v",  {30'b0, rsp_valid}, 32'd2);
    check("single_rsp_r",  rsp_result, 32'd12);
    step();
    check("single_rsp_end", {30'b0, rsp_valid}, 32'd0);
    check("single_idle_a",  alu_a, 32'd0);
    check("single_idle_busy", {31'b0, busy}, 32'd0);

    // ---- round-robin: req0 10-3, req1 1<2 ----
    a0 = 32'd10; b0 = 32'd3; op0 = OP_SUB;
    a1 = 32'd1;  b1 = 32'd2; op1 = OP_SLTU;
    for (int i = 0; i < 8; i++) begin
      valid = (i < 6) ? 2'b11 : 2'b00;
      #1;
      if (i < 6) check($sformatf("rr_ready%0d", i), {30'b0, req_ready}, {30'b0, rr_ready[i]});
      if (i >= 2) begin
        check($sformatf("rr_rsp_v%0d", i), {30'b0, rsp_valid}, {30'b0, rr_ready[i-2]});
        check($sformatf("rr_rsp_r%0d", i), rsp_result, ((i - 2) % 2 == 0) ? 32'd7 : 32'd1);
      end
      step();
    end
    idle_inputs();
    step();

    // ---- lock: req0 three locked ops, req1 waiting ----
    op0 = OP_ADD; b0 = 32'd1;
    op1 = OP_ADD; a1 = 32'd100; b1 = 32'd0;
    wait1 = 0;
    for (int i = 0; i < 6; i++) begin
      valid[0] = (i < 3);
      lock[0]  = (i < 2);
      valid[1] = (i < 4);
      a0       = 32'd11 + i - 1;
      #1;
      if (i < 4) check($sformatf("lk_ready%0d", i), {30'b0, req_ready}, {30'b0, lk_ready[i]});
      if (valid[1] && !req_ready[1]) wait1++;
      if (i >= 2) begin
        check($sformatf("lk_rsp_v%0d", i), {30'b0, rsp_valid}, {30'b0, lk_ready[i-2]});
        check($sformatf("lk_rsp_r%0d", i), rsp_result, lk_res[i-2]);
      end
      step();
    end
    check("lk_wait1", wait1, 32'd3);
    idle_inputs();
    step();

    // ---- hold after a transfer (rr_ptr=1, so req0 wins) ----
    valid = 2'b01; a0 = 32'd20; b0 = 32'd22; op0 = OP_ADD;
    #1;
    check("hold_pre_grant", {30'b0, req_ready}, 32'd1);
    step();                      // transfer edge k
    hold  = 1'b1;
    valid = 2'b11;
    #1;
    check("hold_no_grant0", {30'b0, req_ready}, 32'd0);
    step();
    check("hold_rsp_v", {30'b0, rsp_valid}, 32'd1);
    check("hold_rsp_r", rsp_result, 32'd42);
    check("hold_no_grant1", {30'b0, req_ready}, 32'd0);
    step();
    check("hold_no_grant2", {30'b0, req_ready}, 32'd0);
    check("hold_busy", {31'b0, busy}, 32'd0);
    hold = 1'b0;
    #1;
    check("hold_next_grant", {30'b0, req_ready}, 32'd2);
    idle_inputs();
    step();

    // ---- reset mid-flight ----
    valid = 2'b10; a1 = 32'd3; b1 = 32'd4; op1 = OP_ADD;
    #1;
    check("mf_grant", {30'b0, req_ready}, 32'd2);
    step();                      // transfer edge k
    valid = 2'b00;
    rst   = 1'b1;
    step();                      // reset edge k+1
    rst = 1'b0;
    check("mf_rsp_v0", {30'b0, rsp_valid}, 32'd0);
    check("mf_busy0",  {31'b0, busy}, 32'd0);
    step();
    check("mf_rsp_v1", {30'b0, rsp_valid}, 32'd0);
    check("mf_busy1",  {31'b0, busy}, 32'd0);
    step();

    // ---- final report ----
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
